// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory bus plus decode valid/ready handshake
interface instr_fetch_if #(parameter int WORD_SIZE = 16);
  logic [WORD_SIZE-1:0] pointer;
  logic [WORD_SIZE-1:0] mem_data;
  logic [WORD_SIZE-1:0] instr;
  logic [WORD_SIZE-1:0] instr_pc;
  logic instr_valid;
  logic instr_ready;
  modport master(output pointer, instr, instr_pc, instr_valid, input mem_data, instr_ready);
  modport slave(input pointer, instr, instr_pc, instr_valid, output mem_data, instr_ready);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch into a prefetch FIFO with branch redirect, halt and
// optional address bounds fault (enable with FETCH_BOUNDS_CHECK_EN).
module instr_fetch #(
  parameter int WORD_SIZE = 16,
  parameter int MEM_SIZE = 256,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC = 0
) (
  input logic clk,
  input logic reset,
  instr_fetch_if.master bus,
  input logic branch_taken,
  input logic [WORD_SIZE-1:0] branch_target,
  input logic halt_req,
  output logic halted,
  output logic fault
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
  state_t state, state_n;
  logic [WORD_SIZE-1:0] pc, pc_n, hold_instr, hold_pc;
  logic [WORD_SIZE-1:0] q_instr [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] q_pc [FIFO_DEPTH];
  logic [AW:0] rd, wr, count;
  logic pop, fetch, push, oob, redirect, full;
  assign count = wr - rd;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign bus.pointer = pc;
  assign bus.instr_valid = count != '0;
  // Outputs hold the last shown word while the FIFO is empty
  assign bus.instr = bus.instr_valid ? q_instr[rd[AW-1:0]] : hold_instr;
  assign bus.instr_pc = bus.instr_valid ? q_pc[rd[AW-1:0]] : hold_pc;
  assign pop = bus.instr_valid & bus.instr_ready;
  assign redirect = branch_taken && state != FAULT;
  assign fetch = state == RUN && !redirect && !halt_req && (!full || pop);
`ifdef FETCH_BOUNDS_CHECK_EN
  assign oob = pc >= WORD_SIZE'(MEM_SIZE);
  assign fault = state == FAULT;
`else
  assign oob = 1'b0;
  assign fault = 1'b0;
`endif
  assign push = fetch && !oob;
  assign halted = state == HALT && count == '0;
  always_comb begin
    state_n = redirect ? RUN : (state == RUN && halt_req) ? HALT : (fetch && oob) ? FAULT : state;
    pc_n = redirect ? branch_target : push ? pc + 1'b1 : pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc <= WORD_SIZE'(RESET_PC);
      rd <= '0;
      wr <= '0;
      hold_instr <= '0;
      hold_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      hold_instr <= bus.instr;
      hold_pc <= bus.instr_pc;
      if (redirect) begin
        rd <= '0;
        wr <= '0;
      end else begin
        if (pop) rd <= rd + 1'b1;
        if (push) wr <= wr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr[AW-1:0]] <= bus.mem_data;
      q_pc[wr[AW-1:0]] <= pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios for instr_fetch against a combinational image
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic halt_req = 1'b0;
  logic halted, fault;
  int n_checks = 0;
  int n_fail = 0;
  instr_fetch_if #(.WORD_SIZE(16)) bus();
  instr_fetch dut(.clk(clk), .reset(reset), .bus(bus), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .halted(halted), .fault(fault));
  always #5 clk = ~clk;
  function automatic logic [15:0] img(input logic [7:0] a);
    return a == 8'd0 ? 16'hE304 : a == 8'd1 ? 16'hF300 : {8'hA5, a};
  endfunction
  assign bus.mem_data = img(bus.pointer[7:0]);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    bus.instr_ready = rdy;
    branch_taken = 1'b0;
    halt_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0 || bus.instr_pc !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b instr=%h pc=%h, want 0/0000/0000", bus.instr_valid, bus.instr, bus.instr_pc);
    end
    n_checks++;
    if (halted !== 1'b0 || fault !== 1'b0 || bus.pointer !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_flags: halted=%b fault=%b pointer=%h, want 0/0/0000", halted, fault, bus.pointer);
    end
    reset = 1'b0;
  endtask
  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(k) || bus.instr !== img(8'(k))) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 16'(k), img(8'(k)));
      end
    end
  endtask
  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (bus.pointer !== 16'd2 || bus.instr !== 16'hE304 || bus.instr_pc !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_hold: pointer=%h instr=%h pc=%h, want 0002/E304/0000", bus.pointer, bus.instr, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(k) || bus.instr !== img(8'(k))) begin
        n_fail++;
        $display("FAIL drain[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 16'(k), img(8'(k)));
      end
      step();
    end
  endtask
  task automatic test_branch();
    do_reset(1'b0);
    step();
    step();
    branch_taken = 1'b1;
    branch_target = 16'h000D;
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.pointer !== 16'h000D) begin
      n_fail++;
      $display("FAIL branch_flush: valid=%b pointer=%h, want 0/000D", bus.instr_valid, bus.pointer);
    end
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h000D || bus.instr !== img(8'h0D)) begin
      n_fail++;
      $display("FAIL branch_target: valid=%b pc=%h instr=%h, want 1/000D/%h", bus.instr_valid, bus.instr_pc, bus.instr, img(8'h0D));
    end
    bus.instr_ready = 1'b1;
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h000E || bus.instr !== img(8'h0E)) begin
      n_fail++;
      $display("FAIL branch_next: valid=%b pc=%h instr=%h, want 1/000E/%h", bus.instr_valid, bus.instr_pc, bus.instr, img(8'h0E));
    end
  endtask
  task automatic test_halt();
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) step();
    bus.instr_ready = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.pointer !== 16'd5 || halted !== 1'b0 || bus.instr_pc !== 16'd3) begin
      n_fail++;
      $display("FAIL halt_frozen: pointer=%h halted=%b pc=%h, want 0005/0/0003", bus.pointer, halted, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    step();
    n_checks++;
    if (halted !== 1'b0 || bus.instr_pc !== 16'd4 || bus.instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_drain1: halted=%b pc=%h valid=%b, want 0/0004/1", halted, bus.instr_pc, bus.instr_valid);
    end
    step();
    n_checks++;
    if (halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pointer !== 16'd5) begin
      n_fail++;
      $display("FAIL halt_empty: halted=%b valid=%b pointer=%h, want 1/0/0005", halted, bus.instr_valid, bus.pointer);
    end
    branch_taken = 1'b1;
    branch_target = 16'h0000;
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || bus.pointer !== 16'h0) begin
      n_fail++;
      $display("FAIL halt_resume: halted=%b pointer=%h, want 0/0000", halted, bus.pointer);
    end
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== 16'hE304) begin
      n_fail++;
      $display("FAIL halt_word0: valid=%b pc=%h instr=%h, want 1/0000/E304", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask
  task automatic test_reset_mid();
    do_reset(1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.pointer !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset: valid=%b pointer=%h, want 0/0000", bus.instr_valid, bus.pointer);
    end
    step();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== 16'hE304) begin
      n_fail++;
      $display("FAIL midreset_w0: valid=%b pc=%h instr=%h, want 1/0000/E304", bus.instr_valid, bus.instr_pc, bus.instr);
    end
    bus.instr_ready = 1'b1;
    step();
    n_checks++;
    if (bus.instr_pc !== 16'h1 || bus.instr !== 16'hF300) begin
      n_fail++;
      $display("FAIL midreset_w1: pc=%h instr=%h, want 0001/F300", bus.instr_pc, bus.instr);
    end
  endtask
  task automatic test_bounds();
    do_reset(1'b1);
    step();
    step();
    branch_taken = 1'b1;
    branch_target = 16'h0100;
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.pointer !== 16'h0100) begin
      n_fail++;
      $display("FAIL bounds_redirect: valid=%b pointer=%h, want 0/0100", bus.instr_valid, bus.pointer);
    end
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (fault !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pointer !== 16'h0100) begin
        n_fail++;
        $display("FAIL bounds_fault[%0d]: fault=%b valid=%b pointer=%h, want 1/0/0100", k, fault, bus.instr_valid, bus.pointer);
      end
      step();
    end
    do_reset(1'b1);
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL bounds_clear: fault=%b, want 0", fault);
    end
`else
    n_checks++;
    if (fault !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0100 || bus.instr !== 16'hE304) begin
      n_fail++;
      $display("FAIL bounds_alias: fault=%b valid=%b pc=%h instr=%h, want 0/1/0100/E304", fault, bus.instr_valid, bus.instr_pc, bus.instr);
    end
`endif
  endtask
  initial begin
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_branch();
    test_halt();
    test_reset_mid();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
